axis_packet_buffer: RTL



---
 rtl/axis_packet_buffer_if.sv | 19 +
 rtl/axis_packet_buffer.sv | 111 +++++++++++
 2 files changed

// File: rtl/axis_packet_buffer_if.sv
// AXI-Stream bundle used by axis_packet_buffer on both sides.
//   tdata  : payload word, DATA_WIDTH bits
//   tstrb  : byte strobes, one per payload byte
//   tvalid : source has a word on the bus
//   tlast  : word closes a packet
//   tready : sink accepts the word on this edge
// master drives the payload and tvalid; slave drives tready.
interface axis_packet_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_buffer.sv
// Circular AXI-Stream packet buffer, 2**ADDR_WIDTH entries of {tlast, tstrb, tdata}.
// PACKET_MODE=1 releases words only once a whole packet (tlast word) is stored,
// or when the buffer is completely full with no complete packet (oversize packet).
// PACKET_MODE=0 forwards every word the cycle after it is stored.
// Ports:
//   axis_aclk   : single clock for both streams
//   axis_areset : synchronous active-high reset, clears pointers and counters
//   s01_axis    : upstream stream (slave side, buffer drives tready)
//   m01_axis    : downstream stream (master side, first-word-fall-through)
//   fill_level  : words held, 0..2**ADDR_WIDTH
//   pkt_count   : stored tlast words not yet read out
module axis_packet_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int PACKET_MODE = 1
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  axis_packet_buffer_if.slave   s01_axis,
  axis_packet_buffer_if.master  m01_axis,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int ENTRY_W = DATA_WIDTH + STRB_W + 1;
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  head;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] pkt_cnt;
  logic [ADDR_WIDTH:0] fill_next;
  logic                tready_q;
  logic                wr_en;
  logic                rd_en;
  logic                full;
  logic                empty;
  logic                tvalid_c;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full       = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign fill_level = wr_ptr - rd_ptr;
  assign pkt_count  = pkt_cnt;

  assign head = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Eligibility depends only on registered state, never on m01_axis.tready.
  // Once a word is eligible it stays so until read: pkt_cnt and full can only
  // fall through a read handshake.
  always_comb begin
    tvalid_c = !empty;
    if (PACKET_MODE != 0) begin
      tvalid_c = !empty && ((pkt_cnt != '0) || full);
    end
  end

  assign wr_en = s01_axis.tvalid && tready_q;
  assign rd_en = tvalid_c && m01_axis.tready;

  assign s01_axis.tready = tready_q;
  assign m01_axis.tvalid = tvalid_c;
  // Payload is forced to zero while nothing is presented, so the outputs are
  // clean after reset even though the memory itself is never cleared.
  assign {m01_axis.tlast, m01_axis.tstrb, m01_axis.tdata} = tvalid_c ? head : '0;

  always_comb begin
    fill_next = fill_level;
    if (wr_en && !rd_en) begin
      fill_next = fill_level + ONE;
    end else if (!wr_en && rd_en) begin
      fill_next = fill_level - ONE;
    end
  end

  // Control state: pointers, packet count, registered input-side ready
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE;
      end
      // fill_next is at most DEPTH, so its MSB alone flags a full buffer.
      tready_q <= ~fill_next[ADDR_WIDTH];
      case ({wr_en && s01_axis.tlast, rd_en && m01_axis.tlast})
        2'b10:   pkt_cnt <= pkt_cnt + ONE;
        2'b01:   pkt_cnt <= pkt_cnt - ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Storage: data path, not reset
  always_ff @(posedge axis_aclk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s01_axis.tlast, s01_axis.tstrb, s01_axis.tdata};
    end
  end

endmodule
